clk_gen_multi: RTL

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_multi.sv | 95 +++++++++
 1 files changed

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: NUM_CLOCKS divided clocks from refclk with runtime per-channel reconfiguration and lock tracking.
// Define CLK_GEN_MULTI_PHASE_EN to add per-channel phase lag registers.
module clk_gen_multi #(
  parameter int NUM_CLOCKS = 4,
  parameter int DIV_WIDTH = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic refclk,
  input  logic rst,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [$clog2(NUM_CLOCKS > 1 ? NUM_CLOCKS : 2)-1:0] cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic locked
);
  localparam int CW = $clog2(NUM_CLOCKS > 1 ? NUM_CLOCKS : 2);
  localparam int SW = $clog2(LOCK_CYCLES) + 1;
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV < 2 ? 2 : DEFAULT_DIV);
  localparam logic [1:0] SETTLE = 2'd0;
  localparam logic [1:0] LOCKED = 2'd1;
  localparam logic [1:0] RECONF = 2'd2;
  logic [1:0] state;
  logic [SW-1:0] settle;
  logic [CW-1:0] pend_chan;
  logic [DIV_WIDTH-1:0] pend_div, eff_div;
  logic xfer;
  assign cfg_ready = state == LOCKED;
  assign locked = state == LOCKED;
  assign xfer = cfg_valid && cfg_ready && 32'(cfg_chan) < NUM_CLOCKS;
  assign eff_div = pend_div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : pend_div;
`ifdef CLK_GEN_MULTI_PHASE_EN
  logic [DIV_WIDTH-1:0] pend_phase, eff_phase;
  assign eff_phase = pend_phase >= eff_div ? '0 : pend_phase;
  always_ff @(posedge refclk or posedge rst)
    if (rst) pend_phase <= '0;
    else if (xfer) pend_phase <= cfg_phase;
`else
  logic unused_phase;
  assign unused_phase = ^cfg_phase;
`endif
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state <= SETTLE;
      settle <= '0;
      pend_chan <= '0;
      pend_div <= '0;
    end else if (state == SETTLE) begin
      state <= settle == SW'(LOCK_CYCLES - 1) ? LOCKED : SETTLE;
      settle <= settle + 1'b1;
    end else if (state == LOCKED) begin
      if (xfer) begin
        state <= RECONF;
        pend_chan <= cfg_chan;
        pend_div <= cfg_div;
      end
    end else begin
      state <= SETTLE;
      settle <= '0;
    end
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q, cnt, nd, rl;
    logic hit, oc, oe;
    assign hit = state == RECONF && pend_chan == CW'(i);
    assign nd = hit ? eff_div : div_q;
`ifdef CLK_GEN_MULTI_PHASE_EN
    logic [DIV_WIDTH-1:0] ph_q, np;
    assign np = hit ? eff_phase : ph_q;
    // Reloading to div-phase delays the next wrap to zero by phase cycles
    assign rl = np == '0 ? '0 : nd - np;
    always_ff @(posedge refclk or posedge rst)
      if (rst) ph_q <= '0;
      else ph_q <= np;
`else
    assign rl = '0;
`endif
    always_ff @(posedge refclk or posedge rst)
      if (rst) begin
        div_q <= DEF;
        cnt <= '0;
        oc <= 1'b0;
        oe <= 1'b0;
      end else begin
        div_q <= nd;
        cnt <= state == RECONF ? rl : (cnt == div_q - 1'b1 ? '0 : cnt + 1'b1);
        oc <= cnt < (div_q >> 1);
        oe <= cnt == '0;
      end
    assign outclk[i] = oc;
    assign outclk_en[i] = oe;
  end
endmodule
